// File: rtl/instr_buffer.sv
// Instruction prefetch queue feeding a registered instruction register.
// Define INSTR_BUFFER_PC_EN to carry a 32-bit PC alongside each queued word.
module instr_buffer #(
    parameter int              DW    = 32,
    parameter int              DEPTH = 4,
    parameter logic [DW-1:0]   NOP   = 32'h00000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              im_dout,
    input  logic                       im_valid,
    output logic                       im_ready,
    input  logic                       flush,
    input  logic                       irwr,
    output logic [DW-1:0]              instr,
    output logic                       instr_valid,
`ifdef INSTR_BUFFER_PC_EN
    input  logic [31:0]                pc_in,
    output logic [31:0]                pc_out,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [DW-1:0] instr_r;
    logic          instr_valid_r;
    logic          im_ready_r;
    logic          push_s;
    logic          pop_s;

    // im_ready is a flop of (count < DEPTH), so it never depends on irwr or flush
    assign push_s      = im_valid & im_ready_r;
    assign pop_s       = irwr & (count_r != {CW{1'b0}});
    assign im_ready    = im_ready_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign count       = count_r;

    // Next occupancy: push and pop in the same cycle cancel out
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and the instruction register; reset dominates flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            count_r       <= {CW{1'b0}};
            im_ready_r    <= 1'b1;
            instr_r       <= NOP;
            instr_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_nxt_s;
            im_ready_r <= (count_nxt_s < CW'(DEPTH));
            // The head is read from storage, so a word pushed this edge cannot bypass
            if (irwr) begin
                if (pop_s) begin
                    instr_r       <= mem_r[rd_ptr_r];
                    instr_valid_r <= 1'b1;
                end else begin
                    instr_r       <= NOP;
                    instr_valid_r <= 1'b0;
                end
            end
        end
    end

`ifdef INSTR_BUFFER_PC_EN
    logic [31:0] pc_mem_r [DEPTH];
    logic [31:0] pc_out_r;

    assign pc_out = pc_out_r;

    // PC storage; contents need no reset since only pointers define validity
    always_ff @(posedge clk) begin
        if (push_s && !rst && !flush) begin
            pc_mem_r[wr_ptr_r] <= pc_in;
        end
    end

    // PC output tracks the instruction register
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pc_out_r <= 32'h00000000;
        end else if (irwr) begin
            pc_out_r <= pop_s ? pc_mem_r[rd_ptr_r] : 32'h00000000;
        end
    end
`endif

    // Word storage; contents need no reset since only pointers define validity
    always_ff @(posedge clk) begin
        if (push_s && !rst && !flush) begin
            mem_r[wr_ptr_r] <= im_dout;
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed vector table, wrap sequence,
// and randomized traffic against a queue-based reference model.
module tb_instr_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        im_valid = 1'b0;
    logic        irwr = 1'b0;
    logic [31:0] im_dout = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        im_ready;
    logic [2:0]  count;
`ifdef INSTR_BUFFER_PC_EN
    logic [31:0] pc_in = 32'h0;
    logic [31:0] pc_out;
`endif

    int checks = 0;
    int errors = 0;

    instr_buffer #(.DW(32), .DEPTH(DEPTH), .NOP(32'h00000000)) dut (
        .clk(clk),
        .rst(rst),
        .im_dout(im_dout),
        .im_valid(im_valid),
        .im_ready(im_ready),
        .flush(flush),
        .irwr(irwr),
        .instr(instr),
        .instr_valid(instr_valid),
`ifdef INSTR_BUFFER_PC_EN
        .pc_in(pc_in),
        .pc_out(pc_out),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        f;
        logic        v;
        logic        i;
        logic [31:0] d;
        logic [31:0] e_instr;
        logic        e_v;
        logic [2:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic v, input logic i,
                        input logic [31:0] d);
        rst = r; flush = f; im_valid = v; irwr = i; im_dout = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] ei, input logic ev,
                             input logic [2:0] ec, input logic er);
        chk({tag, "_instr"}, instr, ei);
        chk({tag, "_valid"}, {31'h0, instr_valid}, {31'h0, ev});
        chk({tag, "_count"}, {29'h0, count}, {29'h0, ec});
        chk({tag, "_ready"}, {31'h0, im_ready}, {31'h0, er});
    endtask

    initial begin
        logic [31:0] mq[$];
        logic [31:0] m_instr;
        logic        m_v;
        logic        r, f, v, i, m_rdy;
        logic [31:0] d;

        // rst flush vld irwr din | instr valid count ready
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 3'd0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h11111111, 32'h0,        1'b0, 3'd1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h22222222, 32'h0,        1'b0, 3'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h33333333, 32'h0,        1'b0, 3'd3, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h44444444, 32'h0,        1'b0, 3'd4, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h55555555, 32'h0,        1'b0, 3'd4, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h11111111, 1'b1, 3'd3, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h22222222, 1'b1, 3'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h33333333, 1'b1, 3'd1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h44444444, 1'b1, 3'd0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 3'd0, 1'b1});
        // simultaneous push/pop at count 2
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'hA1A1A1A1, 32'h0,        1'b0, 3'd1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'hA2A2A2A2, 32'h0,        1'b0, 3'd2, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, 32'hA1A1A1A1, 1'b1, 3'd2, 1'b1});
        // flush at count 3 with push and irwr
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'hB3B3B3B3, 32'hA1A1A1A1, 1'b1, 3'd3, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'hCCCCCCCC, 32'h0,        1'b0, 3'd0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 3'd0, 1'b1});
        // no bypass: push into empty queue with irwr
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'hDDDDDDDD, 32'h0,        1'b0, 3'd1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'hDDDDDDDD, 1'b1, 3'd0, 1'b1});
        // reset mid-stream beats push and irwr
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'hEEEEEEEE, 32'hDDDDDDDD, 1'b1, 3'd1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0, 3'd0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 3'd0, 1'b1});

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].r, vecs[k].f, vecs[k].v, vecs[k].i, vecs[k].d);
            check_out($sformatf("vec%0d", k), vecs[k].e_instr, vecs[k].e_v,
                      vecs[k].e_cnt, vecs[k].e_rdy);
        end

        // pointer wrap: steady push+pop keeps one word in flight
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h00000100);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 32'h00000100 + k);
            check_out($sformatf("wrap%0d", k), 32'h00000100 + k - 1, 1'b1, 3'd1, 1'b1);
        end

        // randomized traffic against a queue model
        mq = {};
        m_instr = 32'h0;
        m_v = 1'b0;
        for (int n = 0; n < 500; n++) begin
            r = (n == 0) || ($urandom_range(0, 59) == 0);
            f = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 9) < 7);
            i = ($urandom_range(0, 9) < 5);
            d = $urandom;
            if (r || f) begin
                mq = {};
                m_instr = 32'h0;
                m_v = 1'b0;
            end else begin
                m_rdy = (mq.size() < DEPTH);
                if (i) begin
                    if (mq.size() > 0) begin
                        m_instr = mq.pop_front();
                        m_v = 1'b1;
                    end else begin
                        m_instr = 32'h0;
                        m_v = 1'b0;
                    end
                end
                if (v && m_rdy) mq.push_back(d);
            end
            step(r, f, v, i, d);
            check_out($sformatf("rnd%0d", n), m_instr, m_v, 3'(mq.size()),
                      mq.size() < DEPTH);
        end

`ifdef INSTR_BUFFER_PC_EN
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("pc_reset", pc_out, 32'h0);
        pc_in = 32'h00400000;
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h20080001);
        pc_in = 32'h0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("pc_load", pc_out, 32'h00400000);
        chk("pc_instr", instr, 32'h20080001);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("pc_empty", pc_out, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
